// File: rtl/bsg_channel_narrow_pkg.sv
// Shared types and sizing helpers for the channel narrowing/widening sequencers.
package bsg_channel_narrow_pkg;

  typedef enum logic {
    e_empty,
    e_full
  } state_e;

  function automatic int unsigned num_chunks(int unsigned width_in, int unsigned width_out);
    return (width_in + width_out - 1) / width_out;
  endfunction

  function automatic int unsigned cnt_width(int unsigned chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/bsg_channel_narrow_seq_if.sv
// Handshake bundle between a wide upstream FIFO head and a narrow downstream link.
interface bsg_channel_narrow_seq_if #(
  parameter int unsigned width_in_p  = 32,
  parameter int unsigned width_out_p = 8
);
  logic                   v_i;
  logic [width_in_p-1:0]  data_i;
  logic                   deque_o;
  logic                   v_o;
  logic [width_out_p-1:0] data_o;
  logic                   last_o;
  logic                   yumi_i;

  // slave: the sequencer itself; master: upstream source plus downstream sink
  modport slave  (input  v_i, data_i, yumi_i, output deque_o, v_o, data_o, last_o);
  modport master (output v_i, data_i, yumi_i, input  deque_o, v_o, data_o, last_o);
endinterface

// File: rtl/bsg_channel_narrow_mux.sv
// Combinational chunk selector with zero-padding of the final partial chunk.
module bsg_channel_narrow_mux
  import bsg_channel_narrow_pkg::*;
#(
  parameter bit          lsb_to_msb_p = 1'b1,
  parameter int unsigned width_in_p   = 32,
  parameter int unsigned width_out_p  = 8
) (
  input  logic [width_in_p-1:0]                                          word_i,
  input  logic [cnt_width(num_chunks(width_in_p, width_out_p))-1:0]      cnt_i,
  output logic [width_out_p-1:0]                                         data_o
);

  localparam int unsigned num_chunks_lp = num_chunks(width_in_p, width_out_p);

  logic [num_chunks_lp*width_out_p-1:0] padded;
  int unsigned                          sel;

  always_comb begin
    padded                 = '0;
    padded[width_in_p-1:0] = word_i;
    sel = lsb_to_msb_p ? 32'(cnt_i) : (num_chunks_lp - 1 - 32'(cnt_i));
    data_o = '0;
    // Out-of-range counts (non power-of-two chunk counts) select zero.
    for (int unsigned i = 0; i < num_chunks_lp; i++) begin
      if (sel == i) data_o = padded[i*width_out_p +: width_out_p];
    end
  end

endmodule

// File: rtl/bsg_channel_narrow_seq.sv
// Width-narrowing sequencer: captures one wide word, emits it as narrow chunks under valid/yumi.
// Optional macro BSG_CHANNEL_NARROW_SEQ_STATS_EN adds a saturating words_sent_o counter.
module bsg_channel_narrow_seq
  import bsg_channel_narrow_pkg::*;
#(
  parameter int unsigned width_in_p   = 32,
  parameter int unsigned width_out_p  = 8,
  parameter bit          lsb_to_msb_p = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  bsg_channel_narrow_seq_if.slave  ch
`ifdef BSG_CHANNEL_NARROW_SEQ_STATS_EN
  ,
  output logic [31:0]              words_sent_o
`endif
);

  localparam int unsigned num_chunks_lp = num_chunks(width_in_p, width_out_p);
  localparam int unsigned cnt_width_lp  = cnt_width(num_chunks_lp);
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(num_chunks_lp - 1);

  state_e                  state_q, state_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  logic [width_in_p-1:0]   word_q, word_d;
  logic                    last;
  logic                    deque;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    deque   = 1'b0;
    last    = (state_q == e_full) && (cnt_q == last_cnt_lp);
    case (state_q)
      e_empty: begin
        if (ch.v_i) begin
          deque   = 1'b1;
          word_d  = ch.data_i;
          cnt_d   = '0;
          state_d = e_full;
        end
      end
      e_full: begin
        if (ch.yumi_i) begin
          if (!last) begin
            cnt_d = cnt_q + cnt_width_lp'(1);
          end else begin
            cnt_d = '0;
            // Back-to-back refill keeps the link busy without a bubble.
            if (ch.v_i) begin
              deque  = 1'b1;
              word_d = ch.data_i;
            end else begin
              state_d = e_empty;
            end
          end
        end
      end
      default: state_d = e_empty;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_empty;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  // deque is combinational on v_i, so gate it while reset is held.
  assign ch.deque_o = deque & reset_n_i;
  assign ch.v_o     = (state_q == e_full);
  assign ch.last_o  = last;

  bsg_channel_narrow_mux #(
    .lsb_to_msb_p(lsb_to_msb_p),
    .width_in_p  (width_in_p),
    .width_out_p (width_out_p)
  ) u_mux (
    .word_i(word_q),
    .cnt_i (cnt_q),
    .data_o(ch.data_o)
  );

`ifdef BSG_CHANNEL_NARROW_SEQ_STATS_EN
  logic [31:0] words_q, words_d;

  always_comb begin
    words_d = words_q;
    if (ch.yumi_i && last && (words_q != '1)) words_d = words_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) words_q <= '0;
    else            words_q <= words_d;
  end

  assign words_sent_o = words_q;
`endif

  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    ch.yumi_i |-> ch.v_o);

endmodule

// File: tb/tb_bsg_channel_narrow_seq.sv
// Self-checking bench: directed steps plus random traffic against a word/chunk-index reference model.
module tb_bsg_channel_narrow_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bsg_channel_narrow_seq_if #(.width_in_p(32), .width_out_p(8))  a_if ();
  bsg_channel_narrow_seq_if #(.width_in_p(32), .width_out_p(8))  m_if ();
  bsg_channel_narrow_seq_if #(.width_in_p(32), .width_out_p(12)) c_if ();

  assign m_if.v_i    = a_if.v_i;
  assign m_if.data_i = a_if.data_i;
  assign m_if.yumi_i = a_if.yumi_i;

`ifdef BSG_CHANNEL_NARROW_SEQ_STATS_EN
  logic [31:0] a_ws, m_ws, c_ws;
`endif

  bsg_channel_narrow_seq #(.width_in_p(32), .width_out_p(8), .lsb_to_msb_p(1'b1)) u_a (
    .clk_i(clk), .reset_n_i(rst_n), .ch(a_if)
`ifdef BSG_CHANNEL_NARROW_SEQ_STATS_EN
    , .words_sent_o(a_ws)
`endif
  );
  bsg_channel_narrow_seq #(.width_in_p(32), .width_out_p(8), .lsb_to_msb_p(1'b0)) u_m (
    .clk_i(clk), .reset_n_i(rst_n), .ch(m_if)
`ifdef BSG_CHANNEL_NARROW_SEQ_STATS_EN
    , .words_sent_o(m_ws)
`endif
  );
  bsg_channel_narrow_seq #(.width_in_p(32), .width_out_p(12), .lsb_to_msb_p(1'b1)) u_c (
    .clk_i(clk), .reset_n_i(rst_n), .ch(c_if)
`ifdef BSG_CHANNEL_NARROW_SEQ_STATS_EN
    , .words_sent_o(c_ws)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: index 0 = 32->8 channel (shared by both chunk orders), 1 = 32->12 channel.
  bit          mf[2];
  logic [31:0] mw[2];
  int unsigned mi[2];
  int unsigned msent[2];
  int unsigned mn[2]   = '{4, 3};
  int unsigned mwid[2] = '{8, 12};
  bit          a_dq, c_dq;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_last(int c);
    return mf[c] && (mi[c] == mn[c] - 1);
  endfunction

  function automatic bit m_deq(int c, bit vin, bit yumi);
    return rst_n && vin && (!mf[c] || (yumi && m_last(c)));
  endfunction

  function automatic logic [31:0] chunk(int c, bit lsb);
    int unsigned sel = lsb ? mi[c] : (mn[c] - 1 - mi[c]);
    logic [63:0] w = {32'b0, mw[c]};
    return 32'((w >> (sel * mwid[c])) & ((64'd1 << mwid[c]) - 64'd1));
  endfunction

  task automatic mreset();
    for (int c = 0; c < 2; c++) begin
      mf[c] = 1'b0; mi[c] = 0; msent[c] = 0; mw[c] = '0;
    end
  endtask

  task automatic upd(int c, bit vin, logic [31:0] din, bit yumi);
    bit d;
    if (!rst_n) begin
      mf[c] = 1'b0; mi[c] = 0; msent[c] = 0;
      return;
    end
    d = m_deq(c, vin, yumi);
    if (mf[c] && yumi) begin
      if (m_last(c)) begin
        msent[c]++;
        mf[c] = 1'b0;
        mi[c] = 0;
      end else begin
        mi[c]++;
      end
    end
    if (d) begin
      mf[c] = 1'b1; mw[c] = din; mi[c] = 0;
    end
  endtask

  task automatic settle();
    #1;
    a_dq = m_deq(0, a_if.v_i, a_if.yumi_i);
    c_dq = m_deq(1, c_if.v_i, c_if.yumi_i);
    chk("a_v",    a_if.v_o,     mf[0]);
    chk("a_last", a_if.last_o,  m_last(0));
    chk("a_deq",  a_if.deque_o, a_dq);
    chk("m_v",    m_if.v_o,     mf[0]);
    chk("m_last", m_if.last_o,  m_last(0));
    chk("m_deq",  m_if.deque_o, a_dq);
    chk("c_v",    c_if.v_o,     mf[1]);
    chk("c_last", c_if.last_o,  m_last(1));
    chk("c_deq",  c_if.deque_o, c_dq);
    if (mf[0]) begin
      chk("a_data", a_if.data_o, chunk(0, 1'b1));
      chk("m_data", m_if.data_o, chunk(0, 1'b0));
    end
    if (mf[1]) chk("c_data", c_if.data_o, chunk(1, 1'b1));
`ifdef BSG_CHANNEL_NARROW_SEQ_STATS_EN
    chk("a_words", a_ws, msent[0]);
    chk("m_words", m_ws, msent[0]);
    chk("c_words", c_ws, msent[1]);
`endif
  endtask

  task automatic adv();
    @(posedge clk);
    upd(0, a_if.v_i, a_if.data_i, a_if.yumi_i);
    upd(1, c_if.v_i, c_if.data_i, c_if.yumi_i);
    @(negedge clk);
  endtask

  logic [7:0]  t2[4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [7:0]  t3[8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
  logic [11:0] t5[3] = '{12'h123, 12'hCDE, 12'h0AB};
  logic [31:0] w4;

  initial begin
    mreset();
    a_if.v_i = 1'b1; a_if.data_i = 32'h0BAD_F00D; a_if.yumi_i = 1'b0;
    c_if.v_i = 1'b0; c_if.data_i = '0;            c_if.yumi_i = 1'b0;

    // 1: asynchronous reset, deque held low even with v_i asserted
    #2 rst_n = 1'b0;
    mreset();
    settle();
    chk("t1_deq_in_reset", a_if.deque_o, 1'b0);
    adv();
    a_if.v_i = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t1_idle_v", a_if.v_o, 1'b0);
      adv();
    end

    // 2: single word, continuous consumption
    a_if.v_i = 1'b1; a_if.data_i = 32'hDEADBEEF;
    settle();
    chk("t2_deq", a_if.deque_o, 1'b1);
    adv();
    a_if.v_i = 1'b0; a_if.yumi_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("t2_data", a_if.data_o, t2[k]);
      chk("t2_last", a_if.last_o, k == 3);
      chk("t2_deq0", a_if.deque_o, 1'b0);
      adv();
    end
    a_if.yumi_i = 1'b0;
    settle();
    chk("t2_empty", a_if.v_o, 1'b0);

    // 3: back-to-back words without a bubble
    a_if.v_i = 1'b1; a_if.data_i = 32'h11223344;
    settle();
    adv();
    a_if.data_i = 32'h55667788; a_if.yumi_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) a_if.v_i = 1'b0;
      settle();
      chk("t3_v",    a_if.v_o, 1'b1);
      chk("t3_data", a_if.data_o, t3[k]);
      chk("t3_deq",  a_if.deque_o, k == 3);
      adv();
    end
    a_if.yumi_i = 1'b0;
    settle();
`ifdef BSG_CHANNEL_NARROW_SEQ_STATS_EN
    chk("t3_words", a_ws, 32'd3);
`endif

    // 4: backpressure on chunk 2 with next word waiting
    w4 = $urandom();
    a_if.v_i = 1'b1; a_if.data_i = w4;
    settle(); adv();
    a_if.data_i = $urandom(); a_if.yumi_i = 1'b1;
    settle(); adv();
    settle(); adv();
    a_if.yumi_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("t4_hold_data", a_if.data_o, (w4 >> 16) & 32'hFF);
      chk("t4_hold_last", a_if.last_o, 1'b0);
      chk("t4_no_deq",    a_if.deque_o, 1'b0);
      adv();
    end
    a_if.yumi_i = 1'b1;
    settle(); adv();
    settle();
    chk("t4_deq_on_last", a_if.deque_o, 1'b1);
    adv();
    a_if.v_i = 1'b0;
    for (int k = 0; k < 4; k++) begin settle(); adv(); end
    a_if.yumi_i = 1'b0;
    settle();

    // 5: zero-padded final chunk on the 12-bit channel
    c_if.v_i = 1'b1; c_if.data_i = 32'hABCDE123;
    settle(); adv();
    c_if.v_i = 1'b0; c_if.yumi_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t5_data", c_if.data_o, t5[k]);
      chk("t5_last", c_if.last_o, k == 2);
      adv();
    end
    c_if.yumi_i = 1'b0;
    settle();

    // 6: reset while chunk 1 is presented
    a_if.v_i = 1'b1; a_if.data_i = 32'hCAFE_1234;
    settle(); adv();
    a_if.v_i = 1'b0; a_if.yumi_i = 1'b1;
    settle(); adv();
    #2 rst_n = 1'b0;
    a_if.yumi_i = 1'b0; a_if.v_i = 1'b1;
    mreset();
    settle();
    chk("t6_v_clr",    a_if.v_o, 1'b0);
    chk("t6_last_clr", a_if.last_o, 1'b0);
    chk("t6_deq_clr",  a_if.deque_o, 1'b0);
    adv();
    rst_n = 1'b1;
    a_if.data_i = 32'h0102_0304;
    settle(); adv();
    a_if.v_i = 1'b0; a_if.yumi_i = 1'b1;
    settle();
    chk("t6_restart_chunk0", a_if.data_o, 32'h04);
    adv();
    for (int k = 0; k < 3; k++) begin settle(); adv(); end
    a_if.yumi_i = 1'b0;

    // random traffic on both channel widths
    a_if.v_i = 1'b0; c_if.v_i = 1'b0;
    settle(); adv();
    for (int i = 0; i < 400; i++) begin
      if (!(a_if.v_i && !a_dq)) begin
        a_if.v_i = ($urandom_range(0, 2) != 0);
        a_if.data_i = $urandom();
      end
      a_if.yumi_i = mf[0] && ($urandom_range(0, 3) != 0);
      if (!(c_if.v_i && !c_dq)) begin
        c_if.v_i = ($urandom_range(0, 2) != 0);
        c_if.data_i = $urandom();
      end
      c_if.yumi_i = mf[1] && ($urandom_range(0, 3) != 0);
      settle();
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
